// File: rtl/dcache_pkg.sv
// Shared state encoding, default geometry and address-split helpers for the 2-way data cache.
package dcache_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    localparam int WORD_W_DEF = 32;
    localparam int SETS_DEF   = 16;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;

    typedef logic [LINE_W_DEF-1:0] line_t;
    typedef logic [WORD_W_DEF-1:0] word_t;

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - idx_w(sets) - off_w(line_w);
    endfunction
endpackage

// File: rtl/dcache_2way_ctrl_if.sv
// CPU-side and memory-side signal bundle of the data cache; slave = cache view, master = environment view.
interface dcache_2way_ctrl_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic [ADDR_W-1:0] p1_addr_i;
    logic [WORD_W-1:0] p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [WORD_W-1:0] p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [CNT_W-1:0]  hit_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
               hit_cnt_o, miss_cnt_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
               hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/dcache_way_array.sv
// One cache way: per-set valid/dirty/tag/line storage, combinational read, line refill or single-word write.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int SETS   = SETS_DEF,
    parameter int TAG_W  = 23,
    parameter int LINE_W = LINE_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [$clog2(SETS)-1:0]             i_idx,
    output logic                                o_valid,
    output logic                                o_dirty,
    output logic [TAG_W-1:0]                    o_tag,
    output logic [LINE_W-1:0]                   o_line,
    input  logic                                i_line_we,
    input  logic [TAG_W-1:0]                    i_tag,
    input  logic [LINE_W-1:0]                   i_line,
    input  logic                                i_word_we,
    input  logic [$clog2(LINE_W/WORD_W)-1:0]    i_word_sel,
    input  logic [WORD_W-1:0]                   i_word
);
    localparam int WORDS = LINE_W / WORD_W;

    logic [SETS-1:0]                    r_valid;
    logic [SETS-1:0]                    r_dirty;
    logic [TAG_W-1:0]                   r_tag  [SETS];
    logic [WORDS-1:0][WORD_W-1:0]       r_line [SETS];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_line[i_idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_line_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (i_line_we) begin
            r_tag[i_idx]  <= i_tag;
            r_line[i_idx] <= i_line;
        end else if (i_word_we) begin
            r_line[i_idx][i_word_sel] <= i_word;
        end
    end
endmodule

// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative write-back/write-allocate L1 data cache controller with per-set LRU.
// state       | meaning
// IDLE        | serve hits; a miss latches the event and moves to MISS
// MISS        | pick victim (first invalid, else LRU); dirty victim -> WRITEBACK
// WRITEBACK   | victim line to memory until ack
// REFILL      | fetch requested line; on ack write it into the victim way
// REFILL_DONE | request now hits and is served, back to IDLE
module dcache_2way_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dcache_2way_ctrl_if.slave bus
);
    localparam int OFF_W  = off_w(LINE_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int WSEL_W = OFF_W - BYTE_W;
    localparam int WORDS  = LINE_W / WORD_W;

    state_t                     r_state, w_next;
    logic                       r_victim;
    logic                       r_ack_q;
    logic [SETS-1:0]            r_lru;
    logic [CNT_W-1:0]           r_hit_cnt, r_miss_cnt;

    logic [IDX_W-1:0]           w_idx;
    logic [TAG_W-1:0]           w_tag;
    logic [WSEL_W-1:0]          w_wsel;
    logic                       w_unused_ok;
    logic [1:0]                 w_valid, w_dirty, w_hit_way, w_line_we, w_word_we;
    logic [TAG_W-1:0]           w_tag_rd  [2];
    logic [LINE_W-1:0]          w_line_rd [2];
    logic [WORDS-1:0][WORD_W-1:0] w_hit_words;
    logic                       w_req, w_hit, w_serve, w_vict_sel;
    logic                       w_mem_en, w_mem_wr, w_ack, w_miss_evt;

    assign w_idx       = bus.p1_addr_i[OFF_W +: IDX_W];
    assign w_tag       = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_wsel      = bus.p1_addr_i[OFF_W-1 : BYTE_W];
    assign w_unused_ok = ^bus.p1_addr_i[BYTE_W-1:0];

    for (genvar g = 0; g < 2; g++) begin : g_way
        dcache_way_array #(
            .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W), .WORD_W(WORD_W)
        ) u_way (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .i_idx      (w_idx),
            .o_valid    (w_valid[g]),
            .o_dirty    (w_dirty[g]),
            .o_tag      (w_tag_rd[g]),
            .o_line     (w_line_rd[g]),
            .i_line_we  (w_line_we[g]),
            .i_tag      (w_tag),
            .i_line     (bus.mem_data_i),
            .i_word_we  (w_word_we[g]),
            .i_word_sel (w_wsel),
            .i_word     (bus.p1_data_i)
        );
        assign w_hit_way[g] = w_valid[g] && (w_tag_rd[g] == w_tag);
    end

    assign w_req       = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign w_hit       = |w_hit_way;
    assign w_serve     = w_req & w_hit;
    assign w_hit_words = w_hit_way[1] ? w_line_rd[1] : w_line_rd[0];
    assign w_word_we   = (w_serve && bus.p1_MemWrite_i) ? w_hit_way : 2'b00;
    assign w_vict_sel  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);
    assign w_ack       = w_mem_en & bus.mem_ack_i;

    // r_ack_q holds the request low for one cycle after every ack, so WRITEBACK->REFILL shows a gap.
    always_comb begin
        w_next     = r_state;
        w_mem_en   = 1'b0;
        w_mem_wr   = 1'b0;
        w_line_we  = 2'b00;
        w_miss_evt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_next     = MISS;
                    w_miss_evt = 1'b1;
                end
            end
            MISS: w_next = (w_valid[w_vict_sel] && w_dirty[w_vict_sel]) ? WRITEBACK : REFILL;
            WRITEBACK: begin
                w_mem_en = !r_ack_q;
                w_mem_wr = !r_ack_q;
                if (bus.mem_ack_i && !r_ack_q) w_next = REFILL;
            end
            REFILL: begin
                w_mem_en = !r_ack_q;
                if (bus.mem_ack_i && !r_ack_q) begin
                    w_next              = REFILL_DONE;
                    w_line_we[r_victim] = 1'b1;
                end
            end
            REFILL_DONE: w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_victim   <= 1'b0;
            r_ack_q    <= 1'b0;
            r_lru      <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_ack_q <= w_ack;
            if (r_state == MISS) r_victim <= w_vict_sel;
            if (w_serve) r_lru[w_idx] <= w_hit_way[0];
            if (w_serve && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_miss_evt && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.p1_stall_o   = w_req & ~w_hit;
    assign bus.p1_data_o    = w_serve ? w_hit_words[w_wsel] : '0;
    assign bus.mem_enable_o = w_mem_en;
    assign bus.mem_write_o  = w_mem_wr;
    assign bus.mem_addr_o   = !w_mem_en ? '0 :
                              w_mem_wr  ? {w_tag_rd[r_victim], w_idx, {OFF_W{1'b0}}} :
                                          {w_tag, w_idx, {OFF_W{1'b0}}};
    assign bus.mem_data_o   = w_mem_wr ? w_line_rd[r_victim] : '0;
    assign bus.hit_cnt_o    = r_hit_cnt;
    assign bus.miss_cnt_o   = r_miss_cnt;
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed bench for dcache_2way_ctrl: default build plus a CNT_W=4 build for counter saturation.
module tb_dcache_2way_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    dcache_2way_ctrl_if #(.ADDR_W(32), .LINE_W(256), .WORD_W(32), .CNT_W(32)) bus ();
    dcache_2way_ctrl_if #(.ADDR_W(32), .LINE_W(256), .WORD_W(32), .CNT_W(4))  bus2 ();

    dcache_2way_ctrl #(.ADDR_W(32), .LINE_W(256), .WORD_W(32), .SETS(16), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );
    dcache_2way_ctrl #(.ADDR_W(32), .LINE_W(256), .WORD_W(32), .SETS(16), .CNT_W(4)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [255:0] fill_line = '0;
    logic [31:0]  q_addr [$];
    logic         q_wr   [$];
    logic [255:0] q_data [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    // Memory: log each request, ack three cycles after it is first seen.
    initial begin : mem_model
        forever begin
            @(negedge clk_i);
            if (rst_i && bus.mem_enable_o === 1'b1) begin
                q_addr.push_back(bus.mem_addr_o);
                q_wr.push_back(bus.mem_write_o);
                q_data.push_back(bus.mem_data_o);
                repeat (3) @(posedge clk_i);
                #1;
                bus.mem_data_i = fill_line;
                bus.mem_ack_i  = 1'b1;
                @(posedge clk_i);
                #1;
                bus.mem_ack_i  = 1'b0;
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
        bus.p1_addr_i     = a;
        bus.p1_data_i     = wd;
        bus.p1_MemWrite_i = wr;
        bus.p1_MemRead_i  = !wr;
        stalls = 0;
        @(negedge clk_i);
        while (bus.p1_stall_o === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk_i);
        end
        chk("serve_timeout", (stalls >= 100), 1'b0);
        rd = bus.p1_data_o;
        @(posedge clk_i);
        #1;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin : main
        logic [31:0]  rd;
        logic [255:0] ln;
        int           st;
        int           n;

        bus.p1_addr_i = '0;  bus.p1_data_i = '0;  bus.p1_MemRead_i = 1'b0;  bus.p1_MemWrite_i = 1'b0;
        bus.mem_data_i = '0; bus.mem_ack_i = 1'b0;
        bus2.p1_addr_i = '0; bus2.p1_data_i = '0; bus2.p1_MemRead_i = 1'b0; bus2.p1_MemWrite_i = 1'b0;
        bus2.mem_data_i = '0; bus2.mem_ack_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall",  bus.p1_stall_o,   1'b0);
        chk("rst_en",     bus.mem_enable_o, 1'b0);
        chk("rst_wr",     bus.mem_write_o,  1'b0);
        chk("rst_maddr",  bus.mem_addr_o,   32'h0);
        chk("rst_mdata",  bus.mem_data_o,   256'h0);
        chk("rst_hit",    bus.hit_cnt_o,    32'h0);
        chk("rst_miss",   bus.miss_cnt_o,   32'h0);
        chk("rst_pdata",  bus.p1_data_o,    32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: cold miss on 0x400
        fill_line = mk_line(32'hDEADBEEF);
        access(32'h400, 1'b0, 32'h0, rd, st);
        chk("t1_rdata",   rd, 32'hDEADBEEF);
        chk("t1_stalls",  st, 6);
        chk("t1_nreq",    q_addr.size(), 1);
        chk("t1_maddr",   q_addr[0], 32'h400);
        chk("t1_mwr",     q_wr[0], 1'b0);
        @(negedge clk_i);
        chk("t1_hit",     bus.hit_cnt_o,  32'd1);
        chk("t1_miss",    bus.miss_cnt_o, 32'd1);
        chk("t1_idle_pd", bus.p1_data_o,  32'h0);
        chk("t1_idle_st", bus.p1_stall_o, 1'b0);
        @(posedge clk_i);
        #1;

        // 2: second tag in set 0 fills way1 without write-back
        fill_line = mk_line(32'h60000000);
        access(32'h600, 1'b0, 32'h0, rd, st);
        chk("t2_rdata",  rd, 32'h60000000);
        chk("t2_stalls", st, 6);
        chk("t2_nreq",   q_addr.size(), 2);
        chk("t2_maddr",  q_addr[1], 32'h600);
        chk("t2_mwr",    q_wr[1], 1'b0);
        access(32'h400, 1'b0, 32'h0, rd, st);
        chk("t2_r400",   rd, 32'hDEADBEEF);
        chk("t2_r400_st", st, 0);
        access(32'h600, 1'b0, 32'h0, rd, st);
        chk("t2_r600",   rd, 32'h60000000);
        chk("t2_r600_st", st, 0);
        access(32'h61C, 1'b0, 32'h0, rd, st);
        chk("t2_r61c",   rd, 32'h60000007);

        // 3: write hit
        access(32'h404, 1'b1, 32'h12345678, rd, st);
        chk("t3_wr_st",  st, 0);
        access(32'h404, 1'b0, 32'h0, rd, st);
        chk("t3_r404",   rd, 32'h12345678);
        access(32'h400, 1'b0, 32'h0, rd, st);
        chk("t3_r400",   rd, 32'hDEADBEEF);

        // 4: clean LRU victim, then dirty victim with write-back
        fill_line = mk_line(32'h80000000);
        access(32'h800, 1'b0, 32'h0, rd, st);
        chk("t4_r800",   rd, 32'h80000000);
        chk("t4_st800",  st, 6);
        chk("t4_nreq1",  q_addr.size(), 3);
        chk("t4_maddr1", q_addr[2], 32'h800);
        fill_line = mk_line(32'hA0000000);
        access(32'hA00, 1'b0, 32'h0, rd, st);
        chk("t4_rA00",   rd, 32'hA0000000);
        chk("t4_stA00",  st, 11);
        chk("t4_nreq2",  q_addr.size(), 5);
        chk("t4_wb_addr", q_addr[3], 32'h400);
        chk("t4_wb_wr",  q_wr[3], 1'b1);
        ln = q_data[3];
        chk("t4_wb_w1",  ln[63:32], 32'h12345678);
        chk("t4_wb_w0",  ln[31:0],  32'hDEADBEEF);
        chk("t4_rf_addr", q_addr[4], 32'hA00);
        chk("t4_rf_wr",  q_wr[4], 1'b0);
        @(negedge clk_i);
        chk("t4_hit",    bus.hit_cnt_o,  32'd10);
        chk("t4_miss",   bus.miss_cnt_o, 32'd4);
        @(posedge clk_i);
        #1;

        // 5: reset in the middle of a write-back
        access(32'hA04, 1'b1, 32'hCAFEF00D, rd, st);
        access(32'h800, 1'b0, 32'h0, rd, st);
        bus.p1_addr_i    = 32'hC00;
        bus.p1_MemRead_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!(bus.mem_enable_o === 1'b1 && bus.mem_write_o === 1'b1) && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("t5_wb_timeout", (n >= 50), 1'b0);
        chk("t5_wb_addr", bus.mem_addr_o, 32'hA00);
        ln = bus.mem_data_o;
        chk("t5_wb_w1",   ln[63:32], 32'hCAFEF00D);
        #1;
        rst_i = 1'b0;
        bus.p1_MemRead_i = 1'b0;
        #1;
        chk("t5_rst_en",    bus.mem_enable_o, 1'b0);
        chk("t5_rst_wr",    bus.mem_write_o,  1'b0);
        chk("t5_rst_addr",  bus.mem_addr_o,   32'h0);
        chk("t5_rst_data",  bus.mem_data_o,   256'h0);
        chk("t5_rst_hit",   bus.hit_cnt_o,    32'h0);
        chk("t5_rst_miss",  bus.miss_cnt_o,   32'h0);
        chk("t5_rst_stall", bus.p1_stall_o,   1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        fill_line = mk_line(32'h40040000);
        access(32'h404, 1'b0, 32'h0, rd, st);
        chk("t5_r404",    rd, 32'h40040001);
        chk("t5_st404",   st, 6);
        chk("t5_nreq",    q_addr.size(), 7);
        chk("t5_q5_addr", q_addr[5], 32'hA00);
        chk("t5_rf_addr", q_addr[6], 32'h400);
        chk("t5_rf_wr",   q_wr[6], 1'b0);
        @(negedge clk_i);
        chk("t5_miss",    bus.miss_cnt_o, 32'd1);
        chk("t5_hit",     bus.hit_cnt_o,  32'd1);
        @(posedge clk_i);
        #1;

        // 6: 4-bit hit counter saturates
        bus2.p1_addr_i    = 32'h0;
        bus2.p1_MemRead_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (bus2.mem_enable_o !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("t6_req_timeout", (n >= 50), 1'b0);
        @(posedge clk_i);
        #1;
        bus2.mem_data_i = mk_line(32'h5A5A0000);
        bus2.mem_ack_i  = 1'b1;
        @(posedge clk_i);
        #1;
        bus2.mem_ack_i  = 1'b0;
        @(negedge clk_i);
        chk("t6_stall",  bus2.p1_stall_o, 1'b0);
        chk("t6_rdata",  bus2.p1_data_o,  32'h5A5A0000);
        chk("t6_hit0",   bus2.hit_cnt_o,  4'h0);
        repeat (14) @(posedge clk_i);
        @(negedge clk_i);
        chk("t6_hit14",  bus2.hit_cnt_o,  4'hE);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        chk("t6_hitsat", bus2.hit_cnt_o,  4'hF);
        chk("t6_miss",   bus2.miss_cnt_o, 4'h1);
        bus2.p1_MemRead_i = 1'b0;
        repeat (2) @(posedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
